// File: rtl/peak_history_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : peak_history_writer_if
// Description : Write-side bus from the peak history writer to the history RAM
//               and renderer (address, bank, data, strobe, head, busy).
// Revision    : 1.0
// ============================================================================
interface peak_history_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9,
    parameter int CH_W   = 1
);
    logic [ADDR_W-1:0] wr_addr;
    logic [CH_W-1:0]   wr_ch;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] head;
    logic              busy;

    modport master (output wr_addr, wr_ch, wr_data, wr_en, head, busy);
    modport slave  (input  wr_addr, wr_ch, wr_data, wr_en, head, busy);
endinterface
`default_nettype wire

// File: rtl/peak_history_writer.sv
`default_nettype none
// ============================================================================
// Module      : peak_history_writer
// Description : Per-channel peak capture and circular write of the scrolling
//               peak-history RAM once per DECIM frames, with freeze and clear.
// Revision    : 1.0
// ============================================================================
module peak_history_writer #(
    parameter int DEPTH     = 272,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 9,
    parameter int CHANNELS  = 2,
    parameter int DECIM     = 4,
    parameter int TRIG_LINE = 270,
    parameter int TRIG_PXL  = 478,
    parameter int PXL_W     = 10,
    parameter int LINE_W    = 9,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [PXL_W-1:0]  i_pxl,
    input  wire logic [LINE_W-1:0] i_line,
    input  wire logic              i_sample_valid,
    input  wire logic [CH_W-1:0]   i_sample_ch,
    input  wire logic [DATA_W-1:0] i_sample_data,
    input  wire logic              i_freeze,
    input  wire logic              i_dir,
    input  wire logic              i_clear,
    peak_history_writer_if.master  bus
);
    localparam int FC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   c_LAST_CH   = CH_W'(CHANNELS - 1);
    localparam logic [FC_W-1:0]   c_LAST_FCNT = FC_W'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_head;
    logic [CH_W-1:0]     r_wr_ch;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic                r_busy;
    logic [FC_W-1:0]     r_fcnt;
    logic                r_clr_pend;
    logic                r_match_q;
    logic                r_tick;
    logic [DATA_W-1:0]   r_peak [CHANNELS];

    logic                w_match;
    logic                w_due;
    logic                w_start_write;
    logic                w_rd_en;
    logic [CH_W-1:0]     w_rd_ch;
    logic                w_clr_done;
    logic [ADDR_W-1:0]   w_head_step;
    logic [CHANNELS-1:0] w_hit;

    always_comb begin
        w_match       = (i_line == LINE_W'(TRIG_LINE)) && (i_pxl == PXL_W'(TRIG_PXL));
        w_due         = r_tick && (r_fcnt == c_LAST_FCNT);
        w_start_write = (r_state == S_IDLE) && !i_clear && w_due && !i_freeze;
        // Channel whose peak is handed to the RAM (and reset) on this edge
        w_rd_en       = w_start_write || ((r_state == S_WRITE) && (r_wr_ch != c_LAST_CH));
        w_rd_ch       = (r_state == S_WRITE) ? r_wr_ch + 1'b1 : '0;
        w_clr_done    = (r_state == S_CLEAR) && (r_wr_ch == c_LAST_CH) && (r_wr_addr == c_LAST_ADDR);
        if (i_dir)
            w_head_step = (r_head == c_LAST_ADDR) ? '0 : r_head + 1'b1;
        else
            w_head_step = (r_head == '0) ? c_LAST_ADDR : r_head - 1'b1;
        w_hit = '0;
        for (int c = 0; c < CHANNELS; c++)
            w_hit[c] = i_sample_valid && (i_sample_ch == CH_W'(c));
    end

    // A sample landing on its channel's read edge seeds the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                r_peak[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_clr_done)
                    r_peak[c] <= '0;
                else if (w_rd_en && (w_rd_ch == CH_W'(c)))
                    r_peak[c] <= w_hit[c] ? i_sample_data : '0;
                else if (w_hit[c] && (i_sample_data > r_peak[c]))
                    r_peak[c] <= i_sample_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_addr  <= c_LAST_ADDR;
            r_head     <= c_LAST_ADDR;
            r_wr_ch    <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_fcnt     <= '0;
            r_clr_pend <= 1'b0;
            r_match_q  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_match_q <= w_match;
            r_tick    <= w_match && !r_match_q;

            if (w_clr_done)
                r_fcnt <= '0;
            else if (r_tick)
                r_fcnt <= (r_fcnt == c_LAST_FCNT) ? '0 : r_fcnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (i_clear) begin
                        r_state   <= S_CLEAR;
                        r_wr_addr <= '0;
                        r_wr_ch   <= '0;
                        r_wr_data <= '0;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (w_start_write) begin
                        r_state   <= S_WRITE;
                        r_head    <= w_head_step;
                        r_wr_addr <= w_head_step;
                        r_wr_ch   <= '0;
                        r_wr_data <= r_peak[0];
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (i_clear)
                        r_clr_pend <= 1'b1;
                    if (w_rd_en) begin
                        r_wr_ch   <= w_rd_ch;
                        r_wr_data <= r_peak[w_rd_ch];
                    end else if (r_clr_pend || i_clear) begin
                        // Strobe and busy stay high straight into the sweep
                        r_state    <= S_CLEAR;
                        r_clr_pend <= 1'b0;
                        r_wr_addr  <= '0;
                        r_wr_ch    <= '0;
                        r_wr_data  <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (w_clr_done) begin
                        r_state <= S_IDLE;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_head  <= c_LAST_ADDR;
                    end else if (r_wr_ch == c_LAST_CH) begin
                        r_wr_ch   <= '0;
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end else begin
                        r_wr_ch <= r_wr_ch + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_ch   = r_wr_ch;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_en   = r_wr_en;
    assign bus.head    = r_head;
    assign bus.busy    = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_peak_history_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_history_writer
// Description : Randomised scoreboard bench for peak_history_writer.
// Revision    : 1.0
// ============================================================================
module tb_peak_history_writer;
    localparam int DEPTH = 272, ADDR_W = 9, DATA_W = 9, CHANNELS = 2, DECIM = 4;
    localparam int TRIG_LINE = 270, TRIG_PXL = 478, PXL_W = 10, LINE_W = 9, CH_W = 1;
    localparam int NCYC = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [PXL_W-1:0]  pxl = '0;
    logic [LINE_W-1:0] line = '0;
    logic              sv = 1'b0;
    logic [CH_W-1:0]   sch = '0;
    logic [DATA_W-1:0] sdata = '0;
    logic              freeze = 1'b0;
    logic              dir = 1'b0;
    logic              clear = 1'b0;

    peak_history_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    peak_history_writer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DECIM(DECIM),
        .TRIG_LINE(TRIG_LINE), .TRIG_PXL(TRIG_PXL), .PXL_W(PXL_W), .LINE_W(LINE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_pxl(pxl), .i_line(line),
        .i_sample_valid(sv), .i_sample_ch(sch), .i_sample_data(sdata),
        .i_freeze(freeze), .i_dir(dir), .i_clear(clear), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int ch; int data; } exp_t;
    exp_t exp_q[$];
    bit   exp_busy [NCYC];
    int   exp_head [NCYC];
    int   n_cmp = 0, n_bad = 0;
    bit   in_reset = 1'b1, done = 1'b0;

    // Reference model state: the RAM head, the max seen per channel since its
    // last write, the frame count, and the cycle ranges the block is occupied.
    int m_head, m_fcnt, m_busy_last, m_clear_last, m_is_write, m_pend;
    int m_read_cyc [CHANNELS];
    int m_acc [CHANNELS];
    bit m1, m2;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    task automatic model_reset(input int n);
        exp_q.delete();
        m_head = DEPTH - 1; m_fcnt = 0; m_busy_last = -1; m_clear_last = -1;
        m_is_write = 0; m_pend = 0; m1 = 0; m2 = 0;
        for (int c = 0; c < CHANNELS; c++) begin m_read_cyc[c] = -1; m_acc[c] = 0; end
        for (int i = n; i < NCYC; i++) exp_busy[i] = 1'b0;
        exp_head[n] = DEPTH - 1;
        exp_head[n + 1] = DEPTH - 1;
    endtask

    task automatic start_clear(input int n);
        for (int i = 0; i < DEPTH * CHANNELS; i++) begin
            exp_q.push_back('{n + 1 + i, i / CHANNELS, i % CHANNELS, 0});
            exp_busy[n + 1 + i] = 1'b1;
        end
        m_busy_last = n + DEPTH * CHANNELS;
        m_clear_last = m_busy_last;
        m_is_write = 0;
    endtask

    task automatic start_write(input int n, input bit d);
        m_head = (m_head + (d ? 1 : DEPTH - 1)) % DEPTH;
        for (int c = 0; c < CHANNELS; c++) begin
            m_read_cyc[c] = n + c;
            exp_busy[n + 1 + c] = 1'b1;
        end
        m_busy_last = n + CHANNELS;
        m_is_write = 1;
    endtask

    task automatic model_cycle(input int n, input bit m, input bit v, input int ch, input int d,
                               input bit clr, input bit frz, input bit dr);
        bit due;
        due = 1'b0;
        if (m1 && !m2) begin
            due = (m_fcnt == DECIM - 1);
            m_fcnt = (m_fcnt + 1) % DECIM;
        end
        if (n > m_busy_last) begin
            if (clr) start_clear(n);
            else if (due && !frz) start_write(n, dr);
        end else if (clr && m_is_write != 0) begin
            m_pend = 1;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (m_read_cyc[c] == n) begin
                exp_q.push_back('{n + 1, m_head, c, m_acc[c]});
                m_acc[c] = 0;
            end
        end
        if (v && ch < CHANNELS && d > m_acc[ch]) m_acc[ch] = d;
        if (m_is_write != 0 && n == m_busy_last && m_pend != 0) begin
            m_pend = 0;
            start_clear(n);
        end
        if (n == m_clear_last) begin
            for (int c = 0; c < CHANNELS; c++) m_acc[c] = 0;
            m_fcnt = 0;
            m_head = DEPTH - 1;
        end
        m2 = m1;
        m1 = m;
        exp_head[n + 1] = m_head;
    endtask

    task automatic step(input bit m, input bit v, input int ch, input int d, input bit clr);
        @(posedge clk);
        #1;
        if (cyc + DEPTH * CHANNELS + 8 >= NCYC) begin
            $display("FAIL cycle_budget: got %0d cycles, required below %0d", cyc, NCYC);
            $fatal(1);
        end
        if (m) begin
            line = LINE_W'(TRIG_LINE); pxl = PXL_W'(TRIG_PXL);
        end else if ($urandom_range(0, 1) == 0) begin
            line = LINE_W'(TRIG_LINE); pxl = PXL_W'(TRIG_PXL + 1);
        end else begin
            line = LINE_W'(TRIG_LINE - 1); pxl = PXL_W'(TRIG_PXL);
        end
        sv = v; sch = CH_W'(ch); sdata = DATA_W'(d); clear = clr;
        model_cycle(cyc, m, v, ch, d, clr, freeze, dir);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic frame(input int mlen, input int gap, input int sprob);
        bit v;
        for (int i = 0; i < gap + mlen; i++) begin
            v = ($urandom_range(0, 99) < sprob);
            step(i >= gap, v, $urandom_range(0, CHANNELS - 1), $urandom_range(0, (1 << DATA_W) - 1), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        rst_n = 1'b0;
        sv = 1'b0; clear = 1'b0; line = '0; pxl = '0;
        #1;
        check("rst_wr_en",   bus.wr_en == 1'b0, bus.wr_en, 0);
        check("rst_busy",    bus.busy == 1'b0, bus.busy, 0);
        check("rst_head",    int'(bus.head) == DEPTH - 1, bus.head, DEPTH - 1);
        check("rst_wr_addr", int'(bus.wr_addr) == DEPTH - 1, bus.wr_addr, DEPTH - 1);
        check("rst_wr_ch",   bus.wr_ch == '0, bus.wr_ch, 0);
        check("rst_wr_data", bus.wr_data == '0, bus.wr_data, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(cyc);
        in_reset = 1'b0;
    endtask

    // Monitor: every write beat must match the scoreboard head entry in time,
    // address, bank and data; busy and head are checked each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!in_reset && !done) begin
                if (bus.wr_en) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL wr_unexpected at cycle %0d: got addr %0d ch %0d data %0d, required no write",
                                 cyc, bus.wr_addr, bus.wr_ch, bus.wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.addr != int'(bus.wr_addr) || e.ch != int'(bus.wr_ch)
                            || e.data != int'(bus.wr_data)) begin
                            n_bad++;
                            $display("FAIL wr_beat: got cycle %0d addr %0d ch %0d data %0d, required cycle %0d addr %0d ch %0d data %0d",
                                     cyc, bus.wr_addr, bus.wr_ch, bus.wr_data, e.cyc, e.addr, e.ch, e.data);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_missing at cycle %0d: got no write, required addr %0d ch %0d data %0d",
                             cyc, e.addr, e.ch, e.data);
                end
                check("busy", bus.busy == exp_busy[cyc], bus.busy, exp_busy[cyc]);
                check("head", int'(bus.head) == exp_head[cyc], bus.head, exp_head[cyc]);
            end
        end
    end

    initial begin
        #(NCYC * 10 + 1000);
        $display("FAIL watchdog: got no end of run, required finish within %0d cycles", NCYC);
        $fatal(1);
    end

    initial begin
        int nclr;
        do_reset();
        // Plain frames: writes every 4th frame, head 270 then 269, zero data
        repeat (8) frame(1, 8, 0);
        // One window of known samples, then an empty window
        step(1'b0, 1'b1, 0, 5, 1'b0);
        step(1'b0, 1'b1, 0, 200, 1'b0);
        step(1'b0, 1'b1, 1, 300, 1'b0);
        step(1'b0, 1'b1, 0, 17, 1'b0);
        repeat (8) frame(1, 8, 0);
        // Clear from idle, then wrap in both directions
        step(1'b0, 1'b0, 0, 0, 1'b1);
        idle(DEPTH * CHANNELS + 10);
        dir = 1'b1;
        repeat (4) frame(1, 8, 0);
        dir = 1'b0;
        repeat (4) frame(1, 8, 0);
        // Freeze over three due writes while ch0 peaks at 90
        freeze = 1'b1;
        for (int f = 0; f < 12; f++) begin
            step(1'b0, 1'b1, 0, (f == 5) ? 90 : $urandom_range(0, 89), 1'b0);
            frame(1, 7, 0);
        end
        freeze = 1'b0;
        repeat (4) frame(1, 8, 0);
        // Clear landing in the middle of a write
        repeat (3) frame(1, 8, 20);
        idle(8);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        idle(DEPTH * CHANNELS + 10);
        // Match held five cycles with samples on the read cycles
        repeat (3) frame(1, 8, 0);
        idle(8);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 77, 1'b0);
        step(1'b1, 1'b1, 1, 88, 1'b0);
        step(1'b1, 1'b1, 1, 40, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        repeat (4) frame(1, 8, 0);
        // Random traffic
        nclr = 0;
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 99) < 10) dir = ~dir;
            if ($urandom_range(0, 99) < 8) freeze = ~freeze;
            if (nclr < 5 && $urandom_range(0, 99) < 3) begin
                nclr++;
                step(1'b0, 1'b1, $urandom_range(0, CHANNELS - 1), $urandom_range(0, 511), 1'b1);
            end
            frame($urandom_range(1, 5), $urandom_range(2, 12), 40);
        end
        freeze = 1'b0;
        // Asynchronous reset in the middle of a clear sweep
        idle(10);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        idle(100);
        do_reset();
        repeat (8) frame(1, 8, 30);
        idle(20);
        @(negedge clk);
        #1;
        done = 1'b1;
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
